// File: rtl/riscv_issue_unit.sv
// riscv_issue_unit: decoded-instruction queue with load/mul-use
// hazard hold and three-level operand forwarding into issue.
`ifndef UNIT_NUM
`define UNIT_NUM 8
`endif

module riscv_issue_unit #(
  parameter int FIFO_DEPTH = 2,
  parameter int UNIT_NUM   = `UNIT_NUM
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_inst,
  input  logic [31:0]         in_pc,
  input  logic [UNIT_NUM-1:0] in_unit_usage,
  input  logic                in_rs1_use,
  input  logic                in_rs2_use,

  input  logic                flush,
  input  logic                pipe_stall,

  output logic [4:0]          rf_ra_addr,
  output logic [4:0]          rf_rb_addr,
  input  logic [31:0]         rf_ra_data,
  input  logic [31:0]         rf_rb_data,

  input  logic                load_stage1,
  input  logic                mul_stage1,
  input  logic [4:0]          rd_stage1,
  input  logic [4:0]          rd_stage2,
  input  logic [4:0]          writeback_rd,
  input  logic [31:0]         result_stage1,
  input  logic [31:0]         result_stage2,
  input  logic [31:0]         writeback_data,

  output logic                issue_valid,
  output logic                issue_stall,
  output logic [31:0]         issue_inst,
  output logic [31:0]         issue_pc,
  output logic [UNIT_NUM-1:0] issue_unit_usage,
  output logic [31:0]         issue_ra_data,
  output logic [31:0]         issue_rb_data
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [31:0]         inst_q  [FIFO_DEPTH];
  logic [31:0]         pc_q    [FIFO_DEPTH];
  logic [UNIT_NUM-1:0] unit_q  [FIFO_DEPTH];
  logic                use1_q  [FIFO_DEPTH];
  logic                use2_q  [FIFO_DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic                has_head;
  logic                push;
  logic                pop;
  logic                load_use;
  logic                src1_hit;
  logic                src2_hit;
  logic [31:0]         head_inst;
  logic [31:0]         head_pc;
  logic [UNIT_NUM-1:0] head_unit;
  logic                head_use1;
  logic                head_use2;
  logic [4:0]          src1;
  logic [4:0]          src2;

  // Operand select: youngest producer wins, x0 is hardwired zero.
  function automatic logic [31:0] fwd(
    input logic [4:0]  src,
    input logic [31:0] rf,
    input logic [4:0]  rd1,
    input logic [31:0] res1,
    input logic [4:0]  rd2,
    input logic [31:0] res2,
    input logic [4:0]  rdw,
    input logic [31:0] resw
  );
    logic [31:0] v;
    v = rf;
    priority case (1'b1)
      (src == 5'd0):               v = '0;
      (rd1 != 5'd0 && rd1 == src): v = res1;
      (rd2 != 5'd0 && rd2 == src): v = res2;
      (rdw != 5'd0 && rdw == src): v = resw;
      default:                     v = rf;
    endcase
    return v;
  endfunction

  assign has_head = (count != '0);
  assign in_ready = (count != FULL_CNT);
  assign push     = in_valid && in_ready && !flush;

  // Head view; an empty queue presents all-zero fields.
  always_comb begin
    head_inst = '0;
    head_pc   = '0;
    head_unit = '0;
    head_use1 = 1'b0;
    head_use2 = 1'b0;
    if (has_head) begin
      head_inst = inst_q[rd_ptr];
      head_pc   = pc_q[rd_ptr];
      head_unit = unit_q[rd_ptr];
      head_use1 = use1_q[rd_ptr];
      head_use2 = use2_q[rd_ptr];
    end
  end

  assign src1 = head_inst[19:15];
  assign src2 = head_inst[24:20];

  assign rf_ra_addr = src1;
  assign rf_rb_addr = src2;

  // Load/mul-use detection against the stage1 destination only.
  always_comb begin
    src1_hit = head_use1 && (src1 != 5'd0) && (src1 == rd_stage1);
    src2_hit = head_use2 && (src2 != 5'd0) && (src2 == rd_stage1);
    load_use = (load_stage1 || mul_stage1) &&
               (rd_stage1 != 5'd0) &&
               (src1_hit || src2_hit);
  end

  assign issue_valid = has_head && !load_use && !flush;
  assign pop         = issue_valid && !pipe_stall;
  assign issue_stall = pipe_stall;

  assign issue_inst       = head_inst;
  assign issue_pc         = head_pc;
  assign issue_unit_usage = head_unit;

  assign issue_ra_data = fwd(src1, rf_ra_data,
                             rd_stage1, result_stage1,
                             rd_stage2, result_stage2,
                             writeback_rd, writeback_data);

  assign issue_rb_data = fwd(src2, rf_rb_data,
                             rd_stage1, result_stage1,
                             rd_stage2, result_stage2,
                             writeback_rd, writeback_data);

  // Pointer and occupancy tracking; flush empties the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage, written at the tail on an accepted push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
        unit_q[i] <= '0;
        use1_q[i] <= 1'b0;
        use2_q[i] <= 1'b0;
      end
    end else if (push) begin
      inst_q[wr_ptr] <= in_inst;
      pc_q[wr_ptr]   <= in_pc;
      unit_q[wr_ptr] <= in_unit_usage;
      use1_q[wr_ptr] <= in_rs1_use;
      use2_q[wr_ptr] <= in_rs2_use;
    end
  end

endmodule

// File: tb/tb_riscv_issue_unit.sv
// tb_riscv_issue_unit: directed stimulus with an issue scoreboard
// checked by an independent negedge monitor.
module tb_riscv_issue_unit;

  localparam int UN = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_inst;
  logic [31:0]   in_pc;
  logic [UN-1:0] in_unit_usage;
  logic          in_rs1_use;
  logic          in_rs2_use;
  logic          flush;
  logic          pipe_stall;
  logic [4:0]    rf_ra_addr;
  logic [4:0]    rf_rb_addr;
  logic [31:0]   rf_ra_data;
  logic [31:0]   rf_rb_data;
  logic          load_stage1;
  logic          mul_stage1;
  logic [4:0]    rd_stage1;
  logic [4:0]    rd_stage2;
  logic [4:0]    writeback_rd;
  logic [31:0]   result_stage1;
  logic [31:0]   result_stage2;
  logic [31:0]   writeback_data;
  logic          issue_valid;
  logic          issue_stall;
  logic [31:0]   issue_inst;
  logic [31:0]   issue_pc;
  logic [UN-1:0] issue_unit_usage;
  logic [31:0]   issue_ra_data;
  logic [31:0]   issue_rb_data;

  typedef struct {
    logic [31:0]   inst;
    logic [31:0]   pc;
    logic [UN-1:0] uu;
    logic [31:0]   ra;
    logic [31:0]   rb;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  riscv_issue_unit #(.FIFO_DEPTH(2), .UNIT_NUM(UN)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc),
    .in_unit_usage(in_unit_usage),
    .in_rs1_use(in_rs1_use), .in_rs2_use(in_rs2_use),
    .flush(flush), .pipe_stall(pipe_stall),
    .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
    .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data),
    .load_stage1(load_stage1), .mul_stage1(mul_stage1),
    .rd_stage1(rd_stage1), .rd_stage2(rd_stage2),
    .writeback_rd(writeback_rd),
    .result_stage1(result_stage1),
    .result_stage2(result_stage2),
    .writeback_data(writeback_data),
    .issue_valid(issue_valid), .issue_stall(issue_stall),
    .issue_inst(issue_inst), .issue_pc(issue_pc),
    .issue_unit_usage(issue_unit_usage),
    .issue_ra_data(issue_ra_data),
    .issue_rb_data(issue_rb_data)
  );

  always #5 clk = ~clk;

  // Register file model: xN reads 0xAA00_00NN.
  assign rf_ra_data = 32'hAA00_0000 | {27'd0, rf_ra_addr};
  assign rf_rb_data = 32'hAA00_0000 | {27'd0, rf_rb_addr};

  function automatic logic [31:0] mk(
    input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [4:0] rd,  input logic [6:0] op
  );
    return {7'd0, rs2, rs1, 3'd0, rd, op};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act === want) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, want);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push_in(input logic [31:0] inst,
                         input logic [31:0] pc,
                         input logic [UN-1:0] uu,
                         input logic u1, input logic u2);
    in_valid      = 1'b1;
    in_inst       = inst;
    in_pc         = pc;
    in_unit_usage = uu;
    in_rs1_use    = u1;
    in_rs2_use    = u2;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_inst  = '0;
    in_pc    = '0;
  endtask

  task automatic expect_issue(input logic [31:0] inst,
                              input logic [31:0] pc,
                              input logic [UN-1:0] uu,
                              input logic [31:0] ra,
                              input logic [31:0] rb);
    exp_t e;
    e.inst = inst; e.pc = pc; e.uu = uu; e.ra = ra; e.rb = rb;
    sb.push_back(e);
  endtask

  // Monitor: every real pop must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && issue_valid && !pipe_stall) begin
      if (sb.size() == 0) begin
        chk("unexpected_issue_pc", issue_pc, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("issue_inst", issue_inst, e.inst);
        chk("issue_pc", issue_pc, e.pc);
        chk("issue_uu", {24'd0, issue_unit_usage}, {24'd0, e.uu});
        chk("issue_ra", issue_ra_data, e.ra);
        chk("issue_rb", issue_rb_data, e.rb);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  logic [31:0] i_a, i_b, i_c, i_d, i_e, i_f, i_g, i_h;

  initial begin
    rst = 1'b1;
    idle_in();
    in_unit_usage = '0;
    in_rs1_use = 1'b0; in_rs2_use = 1'b0;
    flush = 1'b0; pipe_stall = 1'b0;
    load_stage1 = 1'b0; mul_stage1 = 1'b0;
    rd_stage1 = '0; rd_stage2 = '0; writeback_rd = '0;
    result_stage1 = '0; result_stage2 = '0; writeback_data = '0;

    cyc(); cyc();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_issue_inst", issue_inst, 0);
    chk("rst_ra", issue_ra_data, 0);
    chk("rst_rf_addr", rf_ra_addr, 0);
    rst = 1'b0;

    // Back-to-back ALU with stage1 forwarding.
    i_a = mk(5'd0, 5'd5, 5'd1, 7'h13);
    i_b = mk(5'd1, 5'd1, 5'd2, 7'h33);
    cyc();
    push_in(i_a, 32'h0, 8'h01, 1'b1, 1'b0);
    expect_issue(i_a, 32'h0, 8'h01, 32'h0, 32'hAA00_0005);
    settle();
    chk("no_bypass_valid", issue_valid, 0);
    cyc();
    push_in(i_b, 32'h4, 8'h01, 1'b1, 1'b1);
    expect_issue(i_b, 32'h4, 8'h01, 32'd5, 32'd5);
    cyc();
    idle_in();
    rd_stage1 = 5'd1; result_stage1 = 32'd5;
    cyc();
    rd_stage1 = '0; result_stage1 = '0;
    settle();
    chk("empty_after_b2b", issue_valid, 0);

    // Load-use bubble, then stage2 forwarding.
    i_c = mk(5'd1, 5'd0, 5'd3, 7'h33);
    cyc();
    push_in(i_c, 32'h8, 8'h02, 1'b1, 1'b1);
    expect_issue(i_c, 32'h8, 8'h02, 32'h0000_DEAD, 32'h0);
    cyc();
    idle_in();
    load_stage1 = 1'b1; rd_stage1 = 5'd1;
    settle();
    chk("load_use_bubble", issue_valid, 0);
    chk("load_use_head", issue_inst, i_c);
    cyc();
    load_stage1 = 1'b0; rd_stage1 = '0;
    rd_stage2 = 5'd1; result_stage2 = 32'h0000_DEAD;
    cyc();
    rd_stage2 = '0; result_stage2 = '0;

    // Mul-use on rs2; unused rs2 must not hold.
    i_d = mk(5'd0, 5'd6, 5'd4, 7'h33);
    i_e = mk(5'd0, 5'd6, 5'd5, 7'h13);
    cyc();
    push_in(i_d, 32'hC, 8'h04, 1'b1, 1'b1);
    expect_issue(i_d, 32'hC, 8'h04, 32'h0, 32'h1234);
    expect_issue(i_e, 32'h50, 8'h08, 32'h0, 32'h1234);
    cyc();
    push_in(i_e, 32'h50, 8'h08, 1'b1, 1'b0);
    mul_stage1 = 1'b1; rd_stage1 = 5'd6; result_stage1 = 32'h1234;
    settle();
    chk("mul_use_bubble", issue_valid, 0);
    cyc();
    idle_in();
    mul_stage1 = 1'b0;
    cyc();
    mul_stage1 = 1'b1;
    settle();
    chk("unused_rs2_no_hold", issue_valid, 1);
    cyc();
    mul_stage1 = 1'b0; rd_stage1 = '0; result_stage1 = '0;
    settle();
    chk("empty_after_mul", issue_valid, 0);

    // Forward priority on a stalled head.
    i_f = mk(5'd7, 5'd7, 5'd8, 7'h33);
    cyc();
    pipe_stall = 1'b1;
    push_in(i_f, 32'h14, 8'h10, 1'b1, 1'b1);
    cyc();
    idle_in();
    rd_stage1 = 5'd7; rd_stage2 = 5'd7; writeback_rd = 5'd7;
    result_stage1 = 32'd1; result_stage2 = 32'd2;
    writeback_data = 32'd3;
    settle();
    chk("fwd_stage1", issue_ra_data, 32'd1);
    chk("fwd_stage1_rb", issue_rb_data, 32'd1);
    chk("stall_valid", issue_valid, 1);
    chk("issue_stall", issue_stall, 1);
    cyc();
    rd_stage1 = '0;
    settle();
    chk("fwd_stage2", issue_ra_data, 32'd2);
    cyc();
    rd_stage2 = '0;
    settle();
    chk("fwd_wb", issue_ra_data, 32'd3);
    cyc();
    writeback_rd = '0;
    pipe_stall = 1'b0;
    expect_issue(i_f, 32'h14, 8'h10, 32'hAA00_0007, 32'hAA00_0007);
    settle();
    chk("fwd_rf", issue_ra_data, 32'hAA00_0007);
    i_g = mk(5'd0, 5'd0, 5'd9, 7'h33);
    cyc();
    result_stage1 = '0; result_stage2 = '0; writeback_data = '0;
    push_in(i_g, 32'h18, 8'h20, 1'b1, 1'b1);
    expect_issue(i_g, 32'h18, 8'h20, 32'h0, 32'h0);
    cyc();
    idle_in();
    cyc();

    // Full queue under stall, then drain in order.
    i_a = mk(5'd10, 5'd11, 5'd12, 7'h33);
    i_b = mk(5'd12, 5'd13, 5'd14, 7'h33);
    i_c = mk(5'd14, 5'd15, 5'd16, 7'h33);
    expect_issue(i_a, 32'h20, 8'h01, 32'hAA00_000A, 32'hAA00_000B);
    expect_issue(i_b, 32'h24, 8'h02, 32'hAA00_000C, 32'hAA00_000D);
    expect_issue(i_c, 32'h28, 8'h03, 32'hAA00_000E, 32'hAA00_000F);
    pipe_stall = 1'b1;
    push_in(i_a, 32'h20, 8'h01, 1'b1, 1'b1);
    settle();
    chk("full_rdy0", in_ready, 1);
    cyc();
    push_in(i_b, 32'h24, 8'h02, 1'b1, 1'b1);
    settle();
    chk("full_rdy1", in_ready, 1);
    cyc();
    push_in(i_c, 32'h28, 8'h03, 1'b1, 1'b1);
    settle();
    chk("full_rdy2", in_ready, 0);
    cyc();
    pipe_stall = 1'b0;
    settle();
    chk("full_pop_rdy", in_ready, 0);
    chk("full_head", issue_inst, i_a);
    cyc();
    settle();
    chk("rdy_after_pop", in_ready, 1);
    cyc();
    idle_in();
    cyc();
    settle();
    chk("drain_valid", issue_valid, 0);
    chk("drain_rdy", in_ready, 1);

    // Flush with a push offered in the same cycle.
    i_d = mk(5'd1, 5'd2, 5'd3, 7'h33);
    i_e = mk(5'd4, 5'd5, 5'd6, 7'h33);
    i_h = mk(5'd7, 5'd8, 5'd9, 7'h33);
    pipe_stall = 1'b1;
    push_in(i_d, 32'h30, 8'h01, 1'b1, 1'b1);
    cyc();
    push_in(i_e, 32'h34, 8'h01, 1'b1, 1'b1);
    cyc();
    settle();
    chk("flush_pre_full", in_ready, 0);
    cyc();
    pipe_stall = 1'b0;
    flush = 1'b1;
    push_in(i_h, 32'h38, 8'h01, 1'b1, 1'b1);
    settle();
    chk("flush_valid", issue_valid, 0);
    cyc();
    flush = 1'b0;
    idle_in();
    settle();
    chk("post_flush_valid", issue_valid, 0);
    chk("post_flush_rdy", in_ready, 1);
    chk("post_flush_inst", issue_inst, 0);
    cyc(); cyc();

    // Asynchronous reset with one queued entry.
    i_g = mk(5'd3, 5'd4, 5'd5, 7'h33);
    pipe_stall = 1'b1;
    push_in(i_g, 32'h40, 8'h55, 1'b1, 1'b1);
    cyc();
    idle_in();
    settle();
    chk("pre_rst_valid", issue_valid, 1);
    chk("pre_rst_pc", issue_pc, 32'h40);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", issue_valid, 0);
    chk("arst_inst", issue_inst, 0);
    chk("arst_pc", issue_pc, 0);
    chk("arst_uu", {24'd0, issue_unit_usage}, 0);
    chk("arst_ra", issue_ra_data, 0);
    chk("arst_rb", issue_rb_data, 0);
    chk("arst_rf_addr", rf_rb_addr, 0);
    chk("arst_rdy", in_ready, 1);
    cyc();
    rst = 1'b0;
    pipe_stall = 1'b0;
    i_h = mk(5'd2, 5'd0, 5'd6, 7'h33);
    cyc();
    push_in(i_h, 32'h44, 8'h66, 1'b1, 1'b1);
    expect_issue(i_h, 32'h44, 8'h66, 32'hAA00_0002, 32'h0);
    settle();
    chk("post_rst_no_bypass", issue_valid, 0);
    cyc();
    idle_in();
    cyc(); cyc();

    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
